// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for a
// single-port data memory (combinational read, write on posedge).
// Every accepted request runs IDLE -> ACCESS -> RESP, one transaction per
// three cycles. Port 1 is a secondary master (DMA, bench loader).
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req/we/addr/wdata 0,1  requests, held stable until ack
//   ack0, ack1             one-cycle completion pulse (RESP cycle)
//   rdata, err             response data / address error, valid with ack
//   busy                   high in ACCESS and RESP
//   mem_*                  memory pins (Address, WriteData, MemWrite,
//                          MemRead, ReadData)
//
// Build option: define ADDR_CHECK_EN to reject addresses >= DEPTH (the
// memory is left untouched and the ack carries err = 1, rdata = 0).
module dmem_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_prio;
  logic              r_id;
  logic              r_we;
  logic              r_bad;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic              w_bad;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_access;
  logic              w_resp;

  // Winner: a lone requester wins; on contention the prio pointer decides.
  assign w_any   = req0 | req1;
  assign w_win   = req1 & (~req0 | r_prio);
  assign w_we    = w_win ? we1    : we0;
  assign w_addr  = w_win ? addr1  : addr0;
  assign w_wdata = w_win ? wdata1 : wdata0;

`ifdef ADDR_CHECK_EN
  assign w_bad = (w_addr >= ADDR_W'(DEPTH));
`else
  assign w_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Transaction latches, read capture and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio  <= 1'b0;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_win;
            r_we    <= w_we;
            r_bad   <= w_bad;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
          end
        end
        // Writes and rejected addresses return zero data.
        S_ACCESS: r_rdata <= (r_we | r_bad) ? '0 : mem_rdata;
        S_RESP:   r_prio  <= ~r_id;
        default:  r_prio  <= r_prio;
      endcase
    end
  end

  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

  // Address/data only change when a new transaction is latched, so they
  // hold their last values outside ACCESS.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  // rst_n gating keeps a reset edge from committing a write mid-ACCESS.
  assign mem_write = w_access & r_we & ~r_bad & rst_n;
  assign mem_read  = w_access & ~r_we & ~r_bad;

  assign busy  = w_access | w_resp;
  assign ack0  = w_resp & ~r_id;
  assign ack1  = w_resp & r_id;
  assign rdata = w_resp ? r_rdata : '0;
  assign err   = w_resp & r_bad;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (memory image + round-robin pointer).
module tb_dmem_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
`ifdef ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err, busy, mem_write, mem_read;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // Memory device plus a bench-side preload port
  logic [DW-1:0] ram [32];
  logic          pl_en;
  logic [4:0]    pl_addr;
  logic [DW-1:0] pl_data;

  // Reference model state
  logic [DW-1:0] exp_mem [32];
  logic          m_prio;

  int n_vec;
  int n_err;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[4:0]];
  always @(posedge clk) begin
    if (mem_write)  ram[mem_addr[4:0]] <= mem_wdata;
    else if (pl_en) ram[pl_addr]       <= pl_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'($urandom); req1 = 1'($urandom);
    we0 = 1'($urandom);  we1 = 1'($urandom);
    addr0 = AW'($urandom); addr1 = AW'($urandom);
    wdata0 = DW'($urandom); wdata1 = DW'($urandom);
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    step(); step();
    n_vec++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL rst_ack0 got=%0h exp=0", ack0); end
    n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL rst_ack1 got=%0h exp=0", ack1); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write got=%0h exp=0", mem_write); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read got=%0h exp=0", mem_read); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%0h exp=0", err); end
    n_vec++; if (rdata !== 64'd0) begin n_err++; $display("FAIL rst_rdata got=%0h exp=0", rdata); end
    n_vec++; if (mem_addr !== 64'd0) begin n_err++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    n_vec++; if (mem_wdata !== 64'd0) begin n_err++; $display("FAIL rst_mem_wdata got=%0h exp=0", mem_wdata); end
    req0 = 1'b0; req1 = 1'b0;
    // Preload the memory while still in reset; mem[1] = mem[2] = 5.
    for (int i = 0; i < 32; i++) begin
      pl_en   = 1'b1;
      pl_addr = 5'(i);
      pl_data = (i == 1 || i == 2) ? 64'd5 : {$urandom, $urandom};
      exp_mem[i] = pl_data;
      step();
    end
    pl_en = 1'b0;
    rst_n = 1'b1;
    m_prio = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd2;
    step();
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rd_mem_read got=%0h exp=1", mem_read); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rd_mem_write got=%0h exp=0", mem_write); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy got=%0h exp=1", busy); end
    step();
    n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL rd_ack0 got=%0h exp=1", ack0); end
    n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL rd_ack1 got=%0h exp=0", ack1); end
    n_vec++; if (rdata !== 64'd5) begin n_err++; $display("FAIL rd_rdata got=%0h exp=5", rdata); end
    step();
    req0 = 1'b0;
    n_vec++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL rd_ack_pulse got=%0h exp=0", ack0); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rd_idle_read got=%0h exp=0", mem_read); end
    m_prio = 1'b1;
  endtask

  task automatic test_contention();
    rst_n = 1'b0; step(); rst_n = 1'b1; m_prio = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd3; wdata0 = 64'hAA;
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'd4; wdata1 = 64'hBB;
    step();
    n_vec++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL ct_write0 got=%0h exp=1", mem_write); end
    n_vec++; if (mem_addr !== 64'd3) begin n_err++; $display("FAIL ct_addr0 got=%0h exp=3", mem_addr); end
    step();
    n_vec++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_err++; $display("FAIL ct_cyc2 got=%0h%0h exp=01", ack1, ack0); end
    step();
    req0 = 1'b0;
    step();
    n_vec++; if (mem_addr !== 64'd4) begin n_err++; $display("FAIL ct_addr1 got=%0h exp=4", mem_addr); end
    n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL ct_early_ack1 got=%0h exp=0", ack1); end
    step();
    n_vec++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin n_err++; $display("FAIL ct_cyc5 got=%0h%0h exp=10", ack1, ack0); end
    step();
    req1 = 1'b0;
    n_vec++; if (ram[3] !== 64'hAA) begin n_err++; $display("FAIL ct_mem3 got=%0h exp=aa", ram[3]); end
    n_vec++; if (ram[4] !== 64'hBB) begin n_err++; $display("FAIL ct_mem4 got=%0h exp=bb", ram[4]); end
    exp_mem[3] = 64'hAA; exp_mem[4] = 64'hBB;
    m_prio = 1'b0;
  endtask

  task automatic test_fairness();
    logic [4:0] a0, a1, wa;
    logic       w;
    a0 = 5'($urandom); a1 = 5'($urandom);
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(a0);
    req1 = 1'b1; we1 = 1'b0; addr1 = AW'(a1);
    for (int t = 0; t < 4; t++) begin
      w  = m_prio;
      wa = w ? a1 : a0;
      step(); step();
      n_vec++; if (ack0 !== ~w || ack1 !== w) begin n_err++; $display("FAIL fair_grant%0d got=%0h%0h exp_port=%0d", t, ack1, ack0, w); end
      n_vec++; if (rdata !== exp_mem[wa]) begin n_err++; $display("FAIL fair_rdata%0d got=%0h exp=%0h", t, rdata, exp_mem[wa]); end
      m_prio = ~w;
      step();
      // The served port immediately presents a fresh read.
      if (w) begin a1 = 5'($urandom); addr1 = AW'(a1); end
      else   begin a0 = 5'($urandom); addr0 = AW'(a0); end
      if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'd1; wdata1 = 64'h77;
    step();
    n_vec++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL rmw_write_pre got=%0h exp=1", mem_write); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rmw_write_gated got=%0h exp=0", mem_write); end
    step();
    n_vec++; if (ack1 !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmw_dropped got=ack%0h busy%0h exp=0", ack1, busy); end
    n_vec++; if (ram[1] !== 64'd5) begin n_err++; $display("FAIL rmw_mem1 got=%0h exp=5", ram[1]); end
    rst_n = 1'b1; req1 = 1'b0;
    step();
    n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL rmw_no_ack got=%0h exp=0", ack1); end
    m_prio = 1'b0;
  endtask

  task automatic test_addr_check();
    logic [DW-1:0] er;
    er = CHK ? 64'd0 : exp_mem[8];
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd40;
    step();
    n_vec++; if (mem_read !== ~CHK) begin n_err++; $display("FAIL ac_mem_read got=%0h exp=%0h", mem_read, ~CHK); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL ac_mem_write got=%0h exp=0", mem_write); end
    step();
    n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL ac_ack0 got=%0h exp=1", ack0); end
    n_vec++; if (err !== CHK) begin n_err++; $display("FAIL ac_err got=%0h exp=%0h", err, CHK); end
    n_vec++; if (rdata !== er) begin n_err++; $display("FAIL ac_rdata got=%0h exp=%0h", rdata, er); end
    step();
    req0 = 1'b0;
    m_prio = 1'b1;
  endtask

  task automatic test_random();
    logic          pend [2];
    logic          pwe  [2];
    logic [4:0]    pad  [2];
    logic [DW-1:0] pdat [2];
    logic          w;
    logic [DW-1:0] er;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          pwe[p]  = 1'($urandom);
          pad[p]  = 5'($urandom);
          pdat[p] = {$urandom, $urandom};
        end
      end
      req0 = pend[0]; we0 = pwe[0]; addr0 = AW'(pad[0]); wdata0 = pdat[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = AW'(pad[1]); wdata1 = pdat[1];
      if (!pend[0] && !pend[1]) begin
        step();
        n_vec++; if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin n_err++; $display("FAIL rnd_idle%0d got=busy%0h ack%0h%0h exp=0", it, busy, ack1, ack0); end
        continue;
      end
      w = (pend[0] && pend[1]) ? m_prio : pend[1];
      step();
      n_vec++; if (mem_write !== pwe[w] || mem_read !== ~pwe[w] || mem_addr !== AW'(pad[w])) begin
        n_err++; $display("FAIL rnd_access%0d got=w%0h r%0h a%0h exp=w%0h r%0h a%0h", it, mem_write, mem_read, mem_addr, pwe[w], ~pwe[w], pad[w]);
      end
      step();
      er = pwe[w] ? 64'd0 : exp_mem[pad[w]];
      n_vec++; if (ack0 !== ~w || ack1 !== w || err !== 1'b0) begin n_err++; $display("FAIL rnd_ack%0d got=%0h%0h err%0h exp_port=%0d", it, ack1, ack0, err, w); end
      n_vec++; if (rdata !== er) begin n_err++; $display("FAIL rnd_rdata%0d got=%0h exp=%0h", it, rdata, er); end
      if (pwe[w]) exp_mem[pad[w]] = pdat[w];
      m_prio = ~w;
      step();
      pend[w] = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_back_idle%0d got=%0h exp=0", it, busy); end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (ram[i] !== exp_mem[i]) begin n_err++; $display("FAIL rnd_mem%0d got=%0h exp=%0h", i, ram[i], exp_mem[i]); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_reset_mid_write();
    test_addr_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and access sequencer for the single-port 64-bit data memory (32 words, combinational read, write on posedge). It lets the CPU load/store path (port 0) and a secondary master, such as a DMA or bench loader (port 1), share one memory. Each accepted request runs as a fixed three-phase transaction: select, memory access, response. The block drives the memory's Address/WriteData/MemWrite/MemRead pins and returns captured read data to the winning requester.

## Interface
- DATA_W, 64, data width of memory words and request data
- ADDR_W, 64, address width presented to memory
- DEPTH, 32, number of memory words; used only by address checking
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  synchronous reset, active-low
- req0 / req1  input  1  request from port 0 / port 1; held high until ack
- we0 / we1  input  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  input  ADDR_W  word address; stable while req high
- wdata0 / wdata1  input  DATA_W  write data; stable while req high
- ack0 / ack1  output  1  one-cycle completion pulse to port 0 / port 1
- rdata  output  DATA_W  read result; valid only while an ack is high
- err  output  1  address error flag; valid only while an ack is high
- busy  output  1  high in ACCESS and RESP
- mem_addr  output  ADDR_W  to memory Address
- mem_wdata  output  DATA_W  to memory WriteData
- mem_write  output  1  to memory MemWrite
- mem_read  output  1  to memory MemRead
- mem_rdata  input  DATA_W  from memory ReadData

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - With no request pending, stay in IDLE.
  - With one or more requests, choose a winner, latch id_q, we_q, addr_q and wdata_q, then go to ACCESS.
- **Winner selection**
  - If only one port requests, that port wins.
  - If both request, the port named by pointer prio wins.
- **ACCESS**
  - Drive mem_addr = addr_q.
  - Drive mem_wdata = wdata_q.
  - Drive mem_write = we_q & rst_n.
  - Drive mem_read = ~we_q.
  - On the edge leaving ACCESS: the memory performs any write, and the block captures mem_rdata into rdata_q (captures 0 for writes). Then go to RESP.
- **RESP**
  - Assert ack[id_q] for exactly one cycle, with rdata = rdata_q.
  - Set prio to the port not just served, whether or not there was contention.
  - Go to IDLE.
- **Outside ACCESS**
  - mem_write = 0 and mem_read = 0.
  - mem_addr and mem_wdata hold their last values.
- **Requester rule**
  - Drop req, or present a new request, on the cycle after ack.
  - A req seen high in IDLE always counts as a new request.
- **No preemption:** a request arriving during ACCESS or RESP waits for IDLE.
- **Reset**
  - rst_n low at any posedge forces IDLE.
  - prio becomes 0, and all registered state (id_q, we_q, addr_q, wdata_q, rdata_q) becomes 0.
  - Any in-flight transaction is dropped without an ack.
- **Write suppression:** mem_write is gated by rst_n, so no memory write happens on a reset edge, even mid-ACCESS.

## Timing
- **Output values in reset and IDLE:** ack0/ack1, busy, err, mem_write, mem_read and rdata are all 0. mem_addr and mem_wdata are 0 after reset.
- **Latency:** a request sampled in IDLE at cycle N is in ACCESS at N+1, acked at N+2, and the next IDLE is N+3.
- **Throughput:** one transaction per 3 cycles.
- **Worst-case wait under contention:** 3 cycles queued behind the other port, so the ack comes at most 5 cycles after req is sampled.
- **Read data and err:** valid only on the ack cycle; undefined otherwise.

## Configuration
- **ADDR_CHECK_EN defined:**
  - In IDLE, the winner's address is compared against DEPTH.
  - If addr ≥ DEPTH, ACCESS still occurs but with mem_write = 0 and mem_read = 0, so memory is untouched.
  - The RESP cycle then asserts ack with err = 1 and rdata = 0.
  - prio updates normally.
- **ADDR_CHECK_EN undefined:** err is tied to 0, and every address passes through to memory unchanged.

## Test plan
- **Reset values:** hold rst_n low for 2 cycles with random req inputs -> ack0/ack1, busy, mem_write, mem_read and err are all 0, and state is IDLE.
- **Single read:** memory preloaded with mem[2] = 5; req0 = 1, we0 = 0, addr0 = 2 sampled at cycle 0 -> mem_read = 1 at cycle 1; ack0 = 1 with rdata = 5 at cycle 2; ack1 stays 0.
- **Contention after reset:** req0 and req1 rise together; port 0 writes 0xAA to addr 3, port 1 writes 0xBB to addr 4 -> ack0 at cycle 2, ack1 at cycle 5; memory then reads back mem[3] = 0xAA and mem[4] = 0xBB.
- **Fairness:** port 0 re-requests immediately after every ack while req1 stays high -> grants alternate 0,1,0,1 over 4 transactions, with no port served twice in a row.
- **Reset mid-write:** port 1 writes 0x77 to addr 1, and rst_n is pulled low in the ACCESS cycle -> mem_write is 0 at that edge, mem[1] keeps 5, and no ack1 is issued.
- **ADDR_CHECK_EN:** port 0 reads addr 40 -> no mem_read/mem_write pulse; ack0 with err = 1 and rdata = 0. The same test without the macro -> mem_read pulses and err = 0.
